// File: rtl/mips_multicycle_fsm.sv
// Multicycle MIPS control FSM: owns the state register and decodes every
// datapath strobe from it (Moore, plus opcode/funct/zero where used).
module mips_multicycle_fsm #(
  parameter int unsigned STATE_W         = 4,
  parameter int unsigned MEM_WAIT_CYCLES = 1,
  parameter int unsigned ENABLE_IMM      = 1,
  parameter int unsigned COUNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic [STATE_W-1:0] state,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               i_or_d,
  output logic               mem_wr_ena,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [3:0]         aluControl,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH            = 4'd0,
    S_READ_FROM_MEMORY = 4'd1,
    S_EXECUTE          = 4'd2,
    S_ALU_WRITEBACK    = 4'd3,
    S_DECODE           = 4'd4,
    S_MEM_ADDR         = 4'd5,
    S_MEM_READ         = 4'd6,
    S_MEM_WRITEBACK    = 4'd7,
    S_MEM_WRITE        = 4'd8,
    S_BRANCH           = 4'd9,
    S_JUMP             = 4'd10,
    S_IMM_EXECUTE      = 4'd11,
    S_IMM_WRITEBACK    = 4'd12,
    S_ILLEGAL          = 4'd13
  } state_t;

  localparam logic [3:0] ALU_OP_ADD = 4'h0;
  localparam logic [3:0] ALU_OP_SUB = 4'h2;
  localparam logic [3:0] ALU_OP_AND = 4'h4;
  localparam logic [3:0] ALU_OP_OR  = 4'h5;
  localparam logic [3:0] ALU_OP_SLT = 4'hA;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_wait;
  logic               w_wait_done;
  logic               w_in_wait;
  logic               r_illegal;
  logic [COUNT_W-1:0] r_count;
  logic               w_unused_funct_hi;

  assign w_unused_funct_hi = ^funct[5:4];
  assign w_in_wait   = (r_state == S_READ_FROM_MEMORY) || (r_state == S_MEM_READ);
  assign w_wait_done = (r_wait == 4'(MEM_WAIT_CYCLES - 1));

  assign state       = STATE_W'(r_state);
  assign illegal_op  = r_illegal;
  assign instr_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state <= w_next;
      if (w_in_wait && !w_wait_done) r_wait <= r_wait + 4'd1;
      else                           r_wait <= '0;
      // Flag rises together with entry so it is visible in the first ILLEGAL cycle.
      if (w_next == S_ILLEGAL) r_illegal <= 1'b1;
      if (w_next == S_FETCH && r_state != S_FETCH) r_count <= r_count + COUNT_W'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    i_or_d     = 1'b0;
    mem_wr_ena = 1'b0;
    aluSrcA    = 1'b0;
    aluSrcB    = 2'b00;
    aluControl = ALU_OP_ADD;
    pc_src     = 2'b00;
    case (r_state)
      S_FETCH: begin
        aluSrcB  = 2'b01;
        pc_write = 1'b1;
        w_next   = S_READ_FROM_MEMORY;
      end
      S_READ_FROM_MEMORY: begin
        ir_write = w_wait_done;
        if (w_wait_done) w_next = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:                         w_next = S_EXECUTE;
          OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
          OP_BEQ:                           w_next = S_BRANCH;
          OP_J:                             w_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:
            w_next = (ENABLE_IMM != 0) ? S_IMM_EXECUTE : S_ILLEGAL;
          default:                          w_next = S_ILLEGAL;
        endcase
      end
      S_EXECUTE: begin
        aluSrcA    = 1'b1;
        aluControl = funct[3:0];
        w_next     = S_ALU_WRITEBACK;
      end
      S_ALU_WRITEBACK: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        w_next  = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        i_or_d = 1'b1;
        if (w_wait_done) w_next = S_MEM_WRITEBACK;
      end
      S_MEM_WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WRITE: begin
        i_or_d     = 1'b1;
        mem_wr_ena = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA    = 1'b1;
        aluControl = ALU_OP_SUB;
        pc_src     = 2'b01;
        pc_write   = zero;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        w_next   = S_FETCH;
      end
      S_IMM_EXECUTE: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        case (opcode)
          OP_ANDI: aluControl = ALU_OP_AND;
          OP_ORI:  aluControl = ALU_OP_OR;
          OP_SLTI: aluControl = ALU_OP_SLT;
          default: aluControl = ALU_OP_ADD;
        endcase
        w_next = S_IMM_WRITEBACK;
      end
      S_IMM_WRITEBACK: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_FETCH;
    endcase
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      i_or_d     = 1'b0;
      mem_wr_ena = 1'b0;
      aluSrcA    = 1'b0;
      aluSrcB    = 2'b00;
      aluControl = 4'h0;
      pc_src     = 2'b00;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_fsm.sv
// Bench for mips_multicycle_fsm: per-instruction expected cycle traces,
// two instances (3-cycle waits/imm on/4-bit count, 1-cycle waits/imm off).
module tb_mips_multicycle_fsm;

  localparam logic [3:0] S_FETCH = 4'd0, S_READ = 4'd1, S_EXEC = 4'd2, S_ALUWB = 4'd3,
                         S_DECODE = 4'd4, S_MADDR = 4'd5, S_MREAD = 4'd6, S_MEMWB = 4'd7,
                         S_MWRITE = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_IMMX = 4'd11,
                         S_IMMWB = 4'd12, S_ILL = 4'd13;
  localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, JJ = 6'h02,
                         ADDI = 6'h08, ANDI = 6'h0C, ORI = 6'h0D, SLTI = 6'h0A;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  st;
    logic        pcw, irw, rw, rd, m2r, iord, mw, asa;
    logic [1:0]  asb;
    logic [3:0]  alu;
    logic [1:0]  pcs;
    logic        ill;
    logic [31:0] cnt;
  } cyc_t;

  logic clk, rst;
  logic [5:0] op0, fn0, op1, fn1;
  logic z0, z1;
  logic [3:0] st0, st1, alu0, alu1;
  logic pcw0, irw0, rw0, rd0, m2r0, iord0, mw0, asa0, ill0;
  logic pcw1, irw1, rw1, rd1, m2r1, iord1, mw1, asa1, ill1;
  logic [1:0] asb0, pcs0, asb1, pcs1;
  logic [3:0]  cnt0;
  logic [31:0] cnt1;
  logic [20:0] a0, a1;

  assign a0 = {st0, pcw0, irw0, rw0, rd0, m2r0, iord0, mw0, asa0, asb0, alu0, pcs0, ill0};
  assign a1 = {st1, pcw1, irw1, rw1, rd1, m2r1, iord1, mw1, asa1, asb1, alu1, pcs1, ill1};

  mips_multicycle_fsm #(.STATE_W(4), .MEM_WAIT_CYCLES(3), .ENABLE_IMM(1), .COUNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .opcode(op0), .funct(fn0), .zero(z0), .state(st0),
    .pc_write(pcw0), .ir_write(irw0), .reg_write(rw0), .reg_dst(rd0), .mem_to_reg(m2r0),
    .i_or_d(iord0), .mem_wr_ena(mw0), .aluSrcA(asa0), .aluSrcB(asb0), .aluControl(alu0),
    .pc_src(pcs0), .illegal_op(ill0), .instr_count(cnt0));

  mips_multicycle_fsm #(.STATE_W(4), .MEM_WAIT_CYCLES(1), .ENABLE_IMM(0), .COUNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .opcode(op1), .funct(fn1), .zero(z1), .state(st1),
    .pc_write(pcw1), .ir_write(irw1), .reg_write(rw1), .reg_dst(rd1), .mem_to_reg(m2r1),
    .i_or_d(iord1), .mem_wr_ena(mw1), .aluSrcA(asa1), .aluSrcB(asb1), .aluControl(alu1),
    .pc_src(pcs1), .illegal_op(ill1), .instr_count(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0, checks = 0;
  cyc_t q0[$], q1[$];
  logic [31:0] m_cnt[2], mask[2];
  bit m_ill[2], dead[2], imm[2];
  int unsigned wt[2];

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] pk(input cyc_t c);
    return {c.st, c.pcw, c.irw, c.rw, c.rd, c.m2r, c.iord, c.mw, c.asa, c.asb, c.alu, c.pcs, c.ill};
  endfunction

  // Inputs outside the sampling states are random so they must not matter.
  function automatic cyc_t blank(input int d, input logic [3:0] st);
    cyc_t c;
    c     = '0;
    c.op  = 6'($urandom);
    c.fn  = 6'($urandom);
    c.z   = 1'($urandom);
    c.st  = st;
    c.ill = m_ill[d];
    c.cnt = m_cnt[d];
    return c;
  endfunction

  task automatic push(input int d, input cyc_t c);
    if (d == 0) q0.push_back(c);
    else        q1.push_back(c);
  endtask

  task automatic gen(input int d, input logic [5:0] op, input logic [5:0] fn, input logic z);
    cyc_t c;
    bit is_imm;
    if (dead[d]) return;
    is_imm = (op == ADDI) || (op == ANDI) || (op == ORI) || (op == SLTI);
    c = blank(d, S_FETCH); c.pcw = 1'b1; c.asb = 2'b01; push(d, c);
    for (int unsigned i = 0; i < wt[d]; i++) begin
      c = blank(d, S_READ); c.irw = (i == wt[d] - 1); push(d, c);
    end
    c = blank(d, S_DECODE); c.op = op; c.asb = 2'b11; push(d, c);
    if (op == RT) begin
      c = blank(d, S_EXEC); c.fn = fn; c.asa = 1'b1; c.alu = fn[3:0]; push(d, c);
      c = blank(d, S_ALUWB); c.rw = 1'b1; c.rd = 1'b1; push(d, c);
    end else if (op == LW || op == SW) begin
      c = blank(d, S_MADDR); c.op = op; c.asa = 1'b1; c.asb = 2'b10; push(d, c);
      if (op == LW) begin
        for (int unsigned i = 0; i < wt[d]; i++) begin
          c = blank(d, S_MREAD); c.iord = 1'b1; push(d, c);
        end
        c = blank(d, S_MEMWB); c.rw = 1'b1; c.m2r = 1'b1; push(d, c);
      end else begin
        c = blank(d, S_MWRITE); c.iord = 1'b1; c.mw = 1'b1; push(d, c);
      end
    end else if (op == BEQ) begin
      c = blank(d, S_BRANCH); c.z = z; c.asa = 1'b1; c.alu = 4'h2; c.pcs = 2'b01; c.pcw = z;
      push(d, c);
    end else if (op == JJ) begin
      c = blank(d, S_JUMP); c.pcs = 2'b10; c.pcw = 1'b1; push(d, c);
    end else if (imm[d] && is_imm) begin
      c = blank(d, S_IMMX); c.op = op; c.asa = 1'b1; c.asb = 2'b10;
      c.alu = (op == ANDI) ? 4'h4 : (op == ORI) ? 4'h5 : (op == SLTI) ? 4'hA : 4'h0;
      push(d, c);
      c = blank(d, S_IMMWB); c.rw = 1'b1; push(d, c);
    end else begin
      m_ill[d] = 1'b1;
      dead[d]  = 1'b1;
      for (int unsigned i = 0; i < 25; i++) begin
        c = blank(d, S_ILL); push(d, c);
      end
      return;
    end
    m_cnt[d] = (m_cnt[d] + 32'd1) & mask[d];
  endtask

  task automatic gen_rand(input int d, input bit allow_ill);
    logic [5:0] op;
    case ($urandom_range(0, 9))
      0: op = RT;   1: op = LW;   2: op = SW;   3: op = BEQ;  4: op = JJ;
      5: op = ADDI; 6: op = ANDI; 7: op = ORI;  8: op = SLTI;
      default: begin
        if (allow_ill && $urandom_range(0, 2) == 0)
          op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h05;
        else op = RT;
      end
    endcase
    gen(d, op, 6'($urandom), 1'($urandom));
  endtask

  task automatic reset_chk();
    chk("rst_d0_state", {28'b0, st0}, {28'b0, S_FETCH});
    chk("rst_d0_strobes", {28'b0, pcw0, irw0, rw0, mw0}, 32'd0);
    chk("rst_d0_illegal", {31'b0, ill0}, 32'd0);
    chk("rst_d0_count", {28'b0, cnt0}, 32'd0);
    chk("rst_d1_state", {28'b0, st1}, {28'b0, S_FETCH});
    chk("rst_d1_strobes", {28'b0, pcw1, irw1, rw1, mw1}, 32'd0);
    chk("rst_d1_illegal", {31'b0, ill1}, 32'd0);
    chk("rst_d1_count", cnt1, 32'd0);
  endtask

  task automatic begin_batch();
    rst = 1'b1;
    @(negedge clk);
    reset_chk();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = '0; m_ill[d] = 1'b0; dead[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic run_batch();
    @(posedge clk); #1;
    rst = 1'b0;
    while (q0.size() > 0 || q1.size() > 0) begin
      if (q0.size() > 0) begin op0 = q0[0].op; fn0 = q0[0].fn; z0 = q0[0].z; end
      if (q1.size() > 0) begin op1 = q1[0].op; fn1 = q1[0].fn; z1 = q1[0].z; end
      @(negedge clk);
      if (q0.size() > 0) begin
        cyc_t e;
        e = q0.pop_front();
        chk($sformatf("d0_ctrl_st%0d", e.st), {11'b0, a0}, {11'b0, pk(e)});
        chk("d0_count", {28'b0, cnt0}, e.cnt);
      end
      if (q1.size() > 0) begin
        cyc_t e;
        e = q1.pop_front();
        chk($sformatf("d1_ctrl_st%0d", e.st), {11'b0, a1}, {11'b0, pk(e)});
        chk("d1_count", cnt1, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    wt[0] = 3; wt[1] = 1; imm[0] = 1'b1; imm[1] = 1'b0;
    mask[0] = 32'hF; mask[1] = 32'hFFFF_FFFF;
    op0 = '0; fn0 = '0; z0 = 1'b0; op1 = '0; fn1 = '0; z1 = 1'b0;
    rst = 1'b1;
    #12;

    // Directed: every instruction class; dut1 hits ori with immediates disabled.
    begin_batch();
    gen(0, RT, 6'h20, 1'b0); gen(0, LW, 6'h00, 1'b0); gen(0, SW, 6'h00, 1'b0);
    gen(0, BEQ, 6'h00, 1'b0); gen(0, BEQ, 6'h00, 1'b1); gen(0, JJ, 6'h00, 1'b0);
    gen(0, ORI, 6'h00, 1'b0); gen(0, ADDI, 6'h00, 1'b0); gen(0, ANDI, 6'h00, 1'b0);
    gen(0, SLTI, 6'h00, 1'b0);
    gen(1, RT, 6'h22, 1'b0); gen(1, LW, 6'h00, 1'b0); gen(1, ORI, 6'h00, 1'b0);
    run_batch();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midread_d0_state", {28'b0, st0}, 32'd1);
    chk("pre_rst_d0_count", {28'b0, cnt0}, 32'd10);
    chk("pre_rst_d1_state", {28'b0, st1}, 32'd13);
    chk("pre_rst_d1_illegal", {31'b0, ill1}, 32'd1);
    chk("pre_rst_d1_count", cnt1, 32'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_d0_state", {28'b0, st0}, 32'd0);
    chk("async_rst_d0_count", {28'b0, cnt0}, 32'd0);
    chk("async_rst_d0_strobes", {28'b0, pcw0, irw0, rw0, mw0}, 32'd0);
    chk("async_rst_d1_illegal", {31'b0, ill1}, 32'd0);

    // Random streams; 4-bit counter on dut0 wraps several times.
    begin_batch();
    for (int i = 0; i < 60; i++) gen_rand(0, 1'b1);
    for (int i = 0; i < 30; i++) gen_rand(1, 1'b1);
    run_batch();

    // Illegal opcode 3F after one retired instruction.
    begin_batch();
    gen(0, RT, 6'($urandom), 1'b0);
    gen(0, 6'h3F, 6'h00, 1'b0);
    for (int i = 0; i < 8; i++) gen_rand(1, 1'b0);
    run_batch();
    chk("ill_d0_state", {28'b0, st0}, 32'd13);
    chk("ill_d0_flag", {31'b0, ill0}, 32'd1);
    chk("ill_d0_count", {28'b0, cnt0}, 32'd1);

    // 15 legal instructions take the 4-bit counter to all-ones; ori wraps it.
    begin_batch();
    for (int i = 0; i < 15; i++) gen_rand(0, 1'b0);
    gen(0, ORI, 6'h00, 1'b0);
    for (int i = 0; i < 10; i++) gen_rand(1, 1'b0);
    run_batch();
    chk("wrap_d0_count", {28'b0, cnt0}, 32'd0);
    chk("wrap_d0_state", {28'b0, st0}, 32'd0);

    begin_batch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
